// File: rtl/mem_bus_if_if.sv
// rtl/mem_bus_if_if.sv - core/memory handshake signal bundle for mem_bus_if
interface mem_bus_if_if;
    logic        REQ;
    logic        RW;
    logic [7:0]  ABL;
    logic [7:0]  ABH;
    logic [7:0]  DB_OUT;
    logic [7:0]  DB_IN;
    logic        STALL;
    logic        BUS_ERR;
    logic        ERR_CLR;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_WE;
    logic        MEM_REQ;
    logic        MEM_ACK;
    logic [7:0]  MEM_RDATA;

    // slave: the bus interface unit; master: core datapath plus memory
    modport slave (
        input  REQ, RW, ABL, ABH, DB_OUT, ERR_CLR, MEM_ACK, MEM_RDATA,
        output DB_IN, STALL, BUS_ERR, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_REQ
    );
    modport master (
        output REQ, RW, ABL, ABH, DB_OUT, ERR_CLR, MEM_ACK, MEM_RDATA,
        input  DB_IN, STALL, BUS_ERR, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_REQ
    );
endinterface

// File: rtl/mem_bus_if.sv
// rtl/mem_bus_if.sv - 6502 bus interface unit: latched request/ack handshake with timeout
module mem_bus_if #(
    parameter logic [7:0] TIMEOUT  = 8'd15,
    parameter logic [7:0] OPEN_BUS = 8'hFF
) (
    input  logic         CLK,
    input  logic         RES_N,
    mem_bus_if_if.slave  bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        req_q, req_d;
    logic [7:0]  db_in_q, db_in_d;
    logic        err_q, err_d;
    logic        err_set;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q <= IDLE;
            wcnt_q  <= 8'h00;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            db_in_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            req_q   <= req_d;
            db_in_q <= db_in_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        req_d   = req_q;
        db_in_d = db_in_q;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.REQ) begin
                    addr_d  = {bus.ABH, bus.ABL};
                    wdata_d = bus.DB_OUT;
                    we_d    = ~bus.RW;
                    req_d   = 1'b1;
                    wcnt_d  = 8'h00;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // ACK is tested first so an ack on the final wait cycle beats the abort
                if (bus.MEM_ACK) begin
                    if (!we_q) begin
                        db_in_d = bus.MEM_RDATA;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else if (wcnt_q == TIMEOUT - 8'd1) begin
                    if (!we_q) begin
                        db_in_d = OPEN_BUS;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_set ? 1'b1 : (bus.ERR_CLR ? 1'b0 : err_q);
    end

    assign bus.STALL     = (state_q == ACCESS);
    assign bus.DB_IN     = db_in_q;
    assign bus.BUS_ERR   = err_q;
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.MEM_WE    = we_q;
    assign bus.MEM_REQ   = req_q;
endmodule

// File: tb/tb_mem_bus_if.sv
// tb/tb_mem_bus_if.sv - scoreboard bench for mem_bus_if (TIMEOUT 15 and 4 instances)
module tb_mem_bus_if;
    logic clk;
    logic res_n;
    int   checks;
    int   failures;

    typedef struct {
        logic [7:0] db;
        logic       err;
        int         stall;
    } exp_t;

    exp_t q15[$];
    exp_t q4[$];

    mem_bus_if_if bus15();
    mem_bus_if_if bus4();

    assign bus4.REQ       = bus15.REQ;
    assign bus4.RW        = bus15.RW;
    assign bus4.ABL       = bus15.ABL;
    assign bus4.ABH       = bus15.ABH;
    assign bus4.DB_OUT    = bus15.DB_OUT;
    assign bus4.ERR_CLR   = bus15.ERR_CLR;
    assign bus4.MEM_ACK   = bus15.MEM_ACK;
    assign bus4.MEM_RDATA = bus15.MEM_RDATA;

    mem_bus_if #(.TIMEOUT(8'd15), .OPEN_BUS(8'hFF)) dut15 (.CLK(clk), .RES_N(res_n), .bus(bus15.slave));
    mem_bus_if #(.TIMEOUT(8'd4),  .OPEN_BUS(8'hFF)) dut4  (.CLK(clk), .RES_N(res_n), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // completion monitor: a falling STALL marks the end of an access
    logic p15, p4;
    int   c15, c4;
    always begin : mon15
        exp_t e;
        @(posedge clk or negedge res_n);
        if (!res_n) begin
            p15 = 1'b0;
            c15 = 0;
        end else begin
            #1;
            if (bus15.STALL) begin
                c15++;
            end else if (p15) begin
                if (q15.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion15: got completion expected none at %0t", $time);
                end else begin
                    e = q15.pop_front();
                    chk("db_in15", {24'h0, bus15.DB_IN}, {24'h0, e.db});
                    chk("bus_err15", {31'h0, bus15.BUS_ERR}, {31'h0, e.err});
                    chk("stall_cycles15", c15, e.stall);
                end
                c15 = 0;
            end
            p15 = bus15.STALL;
        end
    end

    always begin : mon4
        exp_t e;
        @(posedge clk or negedge res_n);
        if (!res_n) begin
            p4 = 1'b0;
            c4 = 0;
        end else begin
            #1;
            if (bus4.STALL) begin
                c4++;
            end else if (p4) begin
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    chk("db_in4", {24'h0, bus4.DB_IN}, {24'h0, e.db});
                    chk("bus_err4", {31'h0, bus4.BUS_ERR}, {31'h0, e.err});
                    chk("stall_cycles4", c4, e.stall);
                end
                c4 = 0;
            end
            p4 = bus4.STALL;
        end
    end

    // waits < 0 means memory never acknowledges
    task automatic access(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                          input int waits, input logic [7:0] rdata,
                          input logic [7:0] exp_db, input logic exp_err, input int exp_stall,
                          input logic clr_last, input logic push4);
        exp_t e;
        e = '{exp_db, exp_err, exp_stall};
        @(negedge clk);
        bus15.REQ = 1'b1;
        bus15.RW = rw;
        bus15.ABH = addr[15:8];
        bus15.ABL = addr[7:0];
        bus15.DB_OUT = wd;
        bus15.MEM_ACK = 1'b0;
        q15.push_back(e);
        if (push4) q4.push_back(e);
        @(posedge clk);
        #1;
        chk("accept_addr", {16'h0, bus15.MEM_ADDR}, {16'h0, addr});
        chk("accept_we", {31'h0, bus15.MEM_WE}, {31'h0, ~rw});
        chk("accept_req", {31'h0, bus15.MEM_REQ}, 32'h1);
        chk("accept_stall", {31'h0, bus15.STALL}, 32'h1);
        if (!rw) chk("accept_wdata", {24'h0, bus15.MEM_WDATA}, {24'h0, wd});
        for (int j = 0; j < exp_stall; j++) begin
            @(negedge clk);
            bus15.REQ = 1'b0;
            bus15.MEM_ACK = (j == waits);
            bus15.MEM_RDATA = rdata;
            bus15.ERR_CLR = clr_last && (j == exp_stall - 1);
            @(posedge clk);
            #1;
            if (j < exp_stall - 1) begin
                chk("held_req", {31'h0, bus15.MEM_REQ}, 32'h1);
                chk("held_addr", {16'h0, bus15.MEM_ADDR}, {16'h0, addr});
                chk("held_we", {31'h0, bus15.MEM_WE}, {31'h0, ~rw});
                if (!rw) chk("held_wdata", {24'h0, bus15.MEM_WDATA}, {24'h0, wd});
            end else begin
                chk("done_req", {31'h0, bus15.MEM_REQ}, 32'h0);
                chk("done_we", {31'h0, bus15.MEM_WE}, 32'h0);
            end
        end
        @(negedge clk);
        bus15.MEM_ACK = 1'b0;
        bus15.ERR_CLR = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        checks = 0;
        failures = 0;
        res_n = 1'b0;
        bus15.REQ = 1'b0;
        bus15.RW = 1'b1;
        bus15.ABL = 8'h00;
        bus15.ABH = 8'h00;
        bus15.DB_OUT = 8'h00;
        bus15.ERR_CLR = 1'b0;
        bus15.MEM_ACK = 1'b0;
        bus15.MEM_RDATA = 8'h00;
        #1;
        chk("rst_db_in", {24'h0, bus15.DB_IN}, 32'h0);
        chk("rst_stall", {31'h0, bus15.STALL}, 32'h0);
        chk("rst_bus_err", {31'h0, bus15.BUS_ERR}, 32'h0);
        chk("rst_mem_req", {31'h0, bus15.MEM_REQ}, 32'h0);
        chk("rst_mem_addr", {16'h0, bus15.MEM_ADDR}, 32'h0);
        chk("rst_mem_we", {31'h0, bus15.MEM_WE}, 32'h0);
        chk("rst_mem_wdata", {24'h0, bus15.MEM_WDATA}, 32'h0);
        repeat (2) @(negedge clk);
        res_n = 1'b1;

        // reset in the middle of an access
        @(negedge clk);
        bus15.REQ = 1'b1;
        bus15.RW = 1'b1;
        bus15.ABH = 8'h12;
        bus15.ABL = 8'h34;
        @(posedge clk);
        #1;
        chk("midrst_req_before", {31'h0, bus15.MEM_REQ}, 32'h1);
        #1;
        res_n = 1'b0;
        bus15.REQ = 1'b0;
        #1;
        chk("midrst_req_async", {31'h0, bus15.MEM_REQ}, 32'h0);
        chk("midrst_stall_async", {31'h0, bus15.STALL}, 32'h0);
        #4;
        res_n = 1'b1;
        @(negedge clk);
        bus15.MEM_ACK = 1'b1;
        bus15.MEM_RDATA = 8'h77;
        @(posedge clk);
        #1;
        chk("late_ack_db_in", {24'h0, bus15.DB_IN}, 32'h0);
        chk("late_ack_stall", {31'h0, bus15.STALL}, 32'h0);
        chk("late_ack_req", {31'h0, bus15.MEM_REQ}, 32'h0);
        @(negedge clk);
        bus15.MEM_ACK = 1'b0;

        access(1'b1, 16'hFFFC, 8'h00,  0, 8'h4C, 8'h4C, 1'b0,  1, 1'b0, 1'b0);
        access(1'b0, 16'h01FD, 8'hA5,  3, 8'h00, 8'h4C, 1'b0,  4, 1'b0, 1'b0);
        access(1'b1, 16'h8000, 8'h00,  3, 8'h12, 8'h12, 1'b0,  4, 1'b0, 1'b1);
        // timeout with ERR_CLR on the abort edge: set must win
        access(1'b1, 16'hFFFF, 8'h00, -1, 8'h55, 8'hFF, 1'b1, 15, 1'b1, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("bus_err_sticky", {31'h0, bus15.BUS_ERR}, 32'h1);
        end
        @(negedge clk);
        bus15.ERR_CLR = 1'b1;
        @(posedge clk);
        #1;
        chk("bus_err_cleared", {31'h0, bus15.BUS_ERR}, 32'h0);
        @(negedge clk);
        bus15.ERR_CLR = 1'b0;

        // back-to-back with REQ held high
        @(negedge clk);
        bus15.REQ = 1'b1;
        bus15.RW = 1'b1;
        bus15.ABH = 8'h00;
        bus15.ABL = 8'h00;
        q15.push_back('{8'hA9, 1'b0, 1});
        q15.push_back('{8'hA9, 1'b0, 1});
        @(posedge clk);
        #1;
        chk("b2b_addr1", {16'h0, bus15.MEM_ADDR}, 32'h0000);
        @(negedge clk);
        bus15.MEM_ACK = 1'b1;
        bus15.MEM_RDATA = 8'hA9;
        bus15.RW = 1'b0;
        bus15.ABH = 8'h02;
        bus15.ABL = 8'h00;
        bus15.DB_OUT = 8'h01;
        @(posedge clk);
        #1;
        chk("b2b_idle_gap", {31'h0, bus15.STALL}, 32'h0);
        @(negedge clk);
        bus15.MEM_ACK = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_accept2", {31'h0, bus15.STALL}, 32'h1);
        chk("b2b_addr2", {16'h0, bus15.MEM_ADDR}, 32'h0200);
        chk("b2b_we2", {31'h0, bus15.MEM_WE}, 32'h1);
        chk("b2b_wdata2", {24'h0, bus15.MEM_WDATA}, 32'h01);
        @(negedge clk);
        bus15.REQ = 1'b0;
        bus15.MEM_ACK = 1'b1;
        bus15.MEM_RDATA = 8'h5A;
        @(posedge clk);
        #1;
        chk("b2b_done2", {31'h0, bus15.STALL}, 32'h0);
        @(negedge clk);
        bus15.MEM_ACK = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue15_drained", q15.size(), 32'h0);
        chk("queue4_drained", q4.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Bus interface unit between the MC6502 datapath and external memory. Each cycle the datapath presents a 16-bit address (ABH:ABL), write data (DB_OUT) and a read/write direction. This block latches them and runs a request/acknowledge handshake with a variable-latency memory. It returns read data on DB_IN and holds the core with STALL until the access completes or times out.

## Interface

Parameters:
- TIMEOUT, 8'd15: maximum ACCESS cycles without MEM_ACK before abort; legal range 1..255.
- OPEN_BUS, 8'hFF: value loaded into DB_IN when a read times out.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RES_N  in  1  reset; asynchronous, active-low.
- REQ  in  1  core requests an access this cycle.
- RW  in  1  direction: 1 = read, 0 = write.
- ABL  in  8  address low byte from datapath.
- ABH  in  8  address high byte from datapath.
- DB_OUT  in  8  write data from datapath.
- DB_IN  out  8  registered read data to datapath (IR/DL/register inputs).
- STALL  out  1  core must hold all state while high.
- BUS_ERR  out  1  sticky timeout flag.
- ERR_CLR  in  1  clears BUS_ERR.
- MEM_ADDR  out  16  latched {ABH, ABL}.
- MEM_WDATA  out  8  latched DB_OUT.
- MEM_WE  out  1  latched write enable (~RW).
- MEM_REQ  out  1  access request to memory.
- MEM_ACK  in  1  memory completes the access.
- MEM_RDATA  in  8  read data, valid when MEM_ACK = 1.

## Operation

- Two-state FSM: IDLE, ACCESS. An 8-bit wait counter WCNT is used in ACCESS.

IDLE:
- REQ = 1 at a rising edge is accepted. Latch MEM_ADDR <= {ABH, ABL}, MEM_WDATA <= DB_OUT, MEM_WE <= ~RW.
- On acceptance: MEM_REQ <= 1, WCNT <= 0, state <= ACCESS.
- REQ = 0: all outputs hold.
- MEM_ACK is ignored.

ACCESS:
- MEM_REQ, MEM_ADDR, MEM_WDATA and MEM_WE are held constant.
- MEM_ACK = 1 at an edge completes the access:
  - Read: DB_IN <= MEM_RDATA.
  - Write: DB_IN unchanged.
  - MEM_REQ <= 0, MEM_WE <= 0, state <= IDLE.
- MEM_ACK = 0 and WCNT == TIMEOUT-1 aborts the access:
  - MEM_REQ <= 0, MEM_WE <= 0, BUS_ERR <= 1, state <= IDLE.
  - Read: DB_IN <= OPEN_BUS. Write: DB_IN unchanged; the write is considered dropped.
- Otherwise WCNT <= WCNT + 1.
- REQ, RW, ABL, ABH and DB_OUT are ignored; the core is stalled.

Outputs and flags:
- STALL = (state == ACCESS), decoded directly from the state register with no input-combinational path.
- DB_IN changes only when a read completes or a read times out.
- BUS_ERR: set on timeout, cleared when ERR_CLR = 1 at an edge. If set and clear occur at the same edge, set wins.
- MEM_WE is never high while MEM_REQ is low.

## Timing

Reset:
- RES_N low asynchronously forces state IDLE, WCNT 0, MEM_ADDR 16'h0000, MEM_WDATA 8'h00, MEM_WE 0, MEM_REQ 0, DB_IN 8'h00, STALL 0, BUS_ERR 0.
- Reset during ACCESS drops MEM_REQ immediately without waiting for a clock. A subsequent late MEM_ACK is ignored.

Latency:
- Edge N accepts the request; MEM_REQ and STALL go high after N.
- A zero-wait memory asserts MEM_ACK before edge N+1. DB_IN is valid and STALL low after N+1, so the core loses exactly 1 cycle.
- With k wait cycles (ACK first seen at edge N+1+k), STALL is high for k+1 cycles.
- Timeout: with no ACK, abort occurs at edge N+TIMEOUT; STALL is high for TIMEOUT cycles.

Boundaries:
- MEM_ACK at the same edge as the final timeout cycle: ACK wins, no BUS_ERR, data captured.
- Back-to-back: REQ in the first IDLE cycle after completion is accepted at the next edge; there is a minimum of 1 IDLE cycle between accesses.
- Address 16'hFFFF is passed unmodified; no address arithmetic in this block.

## Test plan

- Reset mid-access: accept a read, then pulse RES_N low for half a cycle -> MEM_REQ drops within the low phase. After release, STALL 0 and DB_IN 8'h00. An ACK arriving afterwards does not change DB_IN.
- Zero-wait read: REQ=1, RW=1, ABH=8'hFF, ABL=8'hFC, memory ACKs immediately with 8'h4C -> MEM_ADDR=16'hFFFC. STALL high 1 cycle, then DB_IN=8'h4C.
- Wait-state write: REQ=1, RW=0, {ABH,ABL}=16'h01FD, DB_OUT=8'hA5, ACK after 3 wait cycles -> MEM_WE=1 and MEM_WDATA=8'hA5 held 4 cycles; STALL high 4 cycles; DB_IN unchanged.
- Timeout: TIMEOUT=15, read with no ACK -> MEM_REQ drops after 15 cycles, DB_IN=8'hFF, BUS_ERR=1. BUS_ERR stays 1 until ERR_CLR pulse, then 0.
- Ack on last cycle: TIMEOUT=4, ACK with 8'h12 exactly at edge N+4 -> DB_IN=8'h12, BUS_ERR stays 0.
- Back-to-back: read 16'h0000 (returns 8'hA9), then write 16'h0200 with 8'h01, REQ held high continuously -> second access accepted exactly 1 IDLE cycle after the first completes; DB_IN remains 8'hA9 after the write.
